// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 hex keypad scanner. Drives one column low at a time,
//               samples the synchronized rows, debounces over whole scans
//               and reports each new press as a one-cycle key_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                   c_DWELL_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
    localparam int                   c_CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_FULL   = c_CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_kind_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Hex code printed on the key at row/column index {row, col}
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]           r_row_meta;
    logic [3:0]           r_row_s;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [1:0]           r_col_idx;
    logic [3:0]           r_col;
    logic [3:0]           r_slot [4];
    logic                 r_scan_done;
    result_kind_t         r_prev_kind;
    logic [3:0]           r_prev_code;
    logic [c_CNT_W-1:0]   r_stable_cnt;
    state_t               r_state;
    logic [3:0]           r_key;
    logic                 r_key_valid;
    logic                 r_key_held;

    logic                 w_capture;
    logic                 w_any;
    logic                 w_multi;
    logic [3:0]           w_code;
    result_kind_t         w_kind;
    logic                 w_same;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_stable;
    state_t               w_state_next;
    logic [3:0]           w_key_next;
    logic                 w_valid_next;
    logic                 w_held_next;

    // Rows sample at the end of each dwell, leaving time for the column
    // drive to settle and for the synchronizer to catch up.
    assign w_capture = (r_dwell == c_DWELL_LAST);

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    // Dwell counter and one-hot-low column rotation; flags the last column capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell     <= '0;
            r_col_idx   <= 2'd0;
            r_col       <= 4'b1110;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_capture && (r_col_idx == 2'd3);
            if (w_capture) begin
                r_dwell   <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= {r_col[2:0], r_col[3]};
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Capture the synchronized rows into the slot of the active column
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 4'hF;
            end
        end else if (w_capture) begin
            r_slot[r_col_idx] <= r_row_s;
        end
    end

    // Classify the 16 captured bits as none / single key / several keys
    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        w_code  = 4'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!r_slot[c][r]) begin
                    if (w_any) begin
                        w_multi = 1'b1;
                    end
                    w_any  = 1'b1;
                    w_code = key_code(4'(r * 4 + c));
                end
            end
        end
        if (w_multi) begin
            w_kind = RES_MULTI;
        end else if (w_any) begin
            w_kind = RES_SINGLE;
        end else begin
            w_kind = RES_NONE;
        end
    end

    // Run length of identical scan results; a multi-key scan never counts
    always_comb begin
        w_same = (w_kind == r_prev_kind) &&
                 ((w_kind != RES_SINGLE) || (w_code == r_prev_code));
        if (w_kind == RES_MULTI) begin
            w_cnt_next = '0;
        end else if (w_same) begin
            w_cnt_next = (r_stable_cnt == c_CNT_FULL) ? c_CNT_FULL : r_stable_cnt + 1'b1;
        end else begin
            w_cnt_next = c_CNT_W'(1);
        end
        w_stable = (w_cnt_next == c_CNT_FULL);
    end

    // Debounce history, updated once per completed scan
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_cnt <= '0;
            r_prev_kind  <= RES_NONE;
            r_prev_code  <= 4'h0;
        end else if (r_scan_done) begin
            r_stable_cnt <= w_cnt_next;
            r_prev_kind  <= w_kind;
            r_prev_code  <= w_code;
        end
    end

    // Press/release state machine: next state and registered output values
    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_valid_next = 1'b0;
        w_held_next  = r_key_held;
        if (r_scan_done) begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_kind == RES_SINGLE) && w_stable) begin
                        w_state_next = ST_HELD;
                        w_key_next   = w_code;
                        w_valid_next = 1'b1;
                        w_held_next  = 1'b1;
                    end
                end
                ST_HELD: begin
                    // A different key becoming stable is ignored until release
                    if ((w_kind == RES_NONE) && w_stable) begin
                        w_state_next = ST_IDLE;
                        w_held_next  = 1'b0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_held_next  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key       <= w_key_next;
            r_key_valid <= w_valid_next;
            r_key_held  <= w_held_next;
        end
    end

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
